// File: rtl/adam_axil_regs_slv.sv
// AXI-Lite responder terminating a master port in a bank of NO_REGS registers,
// with a read-only mask, byte strobes, SLVERR on bad access and a drain-then-ack pause.
module adam_axil_regs_slv #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NO_REGS     = 8,
  parameter logic [NO_REGS-1:0]    RO_MASK     = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pause_req,
  output logic                          pause_ack,
  input  logic [ADDR_WIDTH-1:0]         aw_addr,
  input  logic [2:0]                    aw_prot,
  input  logic                          aw_valid,
  output logic                          aw_ready,
  input  logic [DATA_WIDTH-1:0]         w_data,
  input  logic [DATA_WIDTH/8-1:0]       w_strb,
  input  logic                          w_valid,
  output logic                          w_ready,
  output logic [1:0]                    b_resp,
  output logic                          b_valid,
  input  logic                          b_ready,
  input  logic [ADDR_WIDTH-1:0]         ar_addr,
  input  logic [2:0]                    ar_prot,
  input  logic                          ar_valid,
  output logic                          ar_ready,
  output logic [DATA_WIDTH-1:0]         r_data,
  output logic [1:0]                    r_resp,
  output logic                          r_valid,
  input  logic                          r_ready,
  output logic [NO_REGS*DATA_WIDTH-1:0] regs_q,
  output logic [NO_REGS-1:0]            regs_we,
  input  logic [NO_REGS*DATA_WIDTH-1:0] hw_rdata
);
  localparam int STRB_WIDTH = DATA_WIDTH/8;
  localparam int OFS        = $clog2(STRB_WIDTH);
  localparam int IW         = ADDR_WIDTH - OFS;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;

  logic [1:0]                           state_q, state_d;
  logic                                 en_q;
  logic                                 aw_held_q, w_held_q;
  logic [IW-1:0]                        aw_idx_q;
  logic [DATA_WIDTH-1:0]                w_data_q;
  logic [STRB_WIDTH-1:0]                w_strb_q;
  logic                                 b_valid_q, r_valid_q;
  logic [1:0]                           b_resp_q, r_resp_q;
  logic [DATA_WIDTH-1:0]                r_data_q;
  logic [NO_REGS-1:0][DATA_WIDTH-1:0]   reg_q;
  logic [NO_REGS-1:0]                   we_q;

  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_commit, wr_ok, rd_ok;
  logic [IW-1:0]         ar_idx;
  logic [NO_REGS-1:0]    wr_hit, rd_hit;
  logic [DATA_WIDTH-1:0] rd_data;

  // en_q keeps every ready low while in reset and for the first cycle after
  assign aw_ready  = en_q & ~aw_held_q & ~b_valid_q & (~pause_req | w_held_q);
  assign w_ready   = en_q & ~w_held_q  & ~b_valid_q & (~pause_req | aw_held_q);
  assign ar_ready  = en_q & ~r_valid_q & ~pause_req;
  assign aw_hs     = aw_valid & aw_ready;
  assign w_hs      = w_valid & w_ready;
  assign b_hs      = b_valid_q & b_ready;
  assign ar_hs     = ar_valid & ar_ready;
  assign r_hs      = r_valid_q & r_ready;
  assign wr_commit = aw_held_q & w_held_q & ~b_valid_q;
  assign ar_idx    = ar_addr[ADDR_WIDTH-1:OFS];

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NO_REGS; i++) begin
      wr_hit[i] = (aw_idx_q == IW'(i));
      rd_hit[i] = (ar_idx == IW'(i));
      if (rd_hit[i]) rd_data = RO_MASK[i] ? hw_rdata[i*DATA_WIDTH +: DATA_WIDTH] : reg_q[i];
    end
    wr_ok = |(wr_hit & ~RO_MASK);
    rd_ok = |rd_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q      <= 1'b0;
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_valid_q <= 1'b0;
      b_resp_q  <= RESP_OKAY;
      we_q      <= '0;
    end else begin
      en_q <= 1'b1;
      if (b_hs) aw_held_q <= 1'b0;
      else if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_idx_q  <= aw_addr[ADDR_WIDTH-1:OFS];
      end
      if (b_hs) w_held_q <= 1'b0;
      else if (w_hs) begin
        w_held_q <= 1'b1;
        w_data_q <= w_data;
        w_strb_q <= w_strb;
      end
      if (wr_commit) begin
        b_valid_q <= 1'b1;
        b_resp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (b_hs) begin
        b_valid_q <= 1'b0;
      end
      we_q <= wr_commit ? (wr_hit & ~RO_MASK) : '0;
    end
  end

  // read-only slots stay zero so regs_q shows only writable contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NO_REGS; i++) reg_q[i] <= RO_MASK[i] ? '0 : RESET_VALUE;
    end else if (wr_commit) begin
      for (int i = 0; i < NO_REGS; i++)
        if (wr_hit[i] && !RO_MASK[i])
          for (int b = 0; b < STRB_WIDTH; b++)
            if (w_strb_q[b]) reg_q[i][8*b +: 8] <= w_data_q[8*b +: 8];
    end
  end

  // r_data samples reg_q before a same-edge write lands: reads see the old value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      r_valid_q <= 1'b1;
      r_data_q  <= rd_data;
      r_resp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (r_hs) begin
      r_valid_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (pause_req) state_d = ST_DRAIN;
      ST_DRAIN:  if (!pause_req) state_d = ST_RUN;
                 else if (!aw_held_q && !w_held_q && !b_valid_q && !r_valid_q) state_d = ST_PAUSED;
      ST_PAUSED: if (!pause_req) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  assign pause_ack = (state_q == ST_PAUSED);
  assign b_valid   = b_valid_q;
  assign b_resp    = b_resp_q;
  assign r_valid   = r_valid_q;
  assign r_data    = r_data_q;
  assign r_resp    = r_resp_q;
  assign regs_q    = reg_q;
  assign regs_we   = we_q;

  logic unused;
  assign unused = ^{aw_prot, ar_prot, aw_addr[OFS-1:0], ar_addr[OFS-1:0]};
endmodule
